param_ctrl: RTL
===============

PARAM_CTRL -- requirements
Module: param_ctrl

Interface
REQ-001 Parameters SHALL be:
  DB_CYCLES  500000  consecutive stable cycles required to accept a button level change (minimum 2)
  FREQ_STEP  16      state_freq increment/decrement per accepted press
  FREQ_INIT  64      state_freq value after reset
  FREQ_MIN   1       lower saturation bound of state_freq
REQ-002 Ports SHALL be:
  clk          in   1   system clock; all logic on its rising edge
  rst          in   1   synchronous reset, active-high
  btn_mode     in   1   asynchronous raw button: advance edit mode
  btn_up       in   1   asynchronous raw button: increase selected parameter
  btn_down     in   1   asynchronous raw button: decrease selected parameter
  btn_en       in   1   asynchronous raw button: toggle output enable
  en           out  1   waveform output enable to the sine generator
  state_freq   out  12  phase-accumulator step to the sine generator
  state_amp    out  3   amplitude divisor to the sine generator, range 1..7
  state_phase  out  8   phase offset to the sine generator
  mode         out  2   current edit mode: 0 FREQ, 1 AMP, 2 PHASE
REQ-003 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Function
REQ-004 Each button SHALL pass through its own two-flop synchronizer before any other use.
REQ-005 Each button SHALL have an independent debouncer: a counter and a debounced level db.
  - The counter clears while the synchronized level equals db.
  - The counter increments while the synchronized level differs from db.
  - When the counter equals DB_CYCLES-1 and the levels still differ, db takes the synchronized level and the counter clears.
REQ-006 Input pulses or glitches shorter than DB_CYCLES cycles after synchronization SHALL never change db.
REQ-007 A press SHALL be recognised only on a db rising edge (db high, previous db low), producing exactly one single-cycle pulse; a release SHALL produce no pulse.
REQ-008 With the raw button first sampled high at edge 1 and held, the affected output SHALL change at edge DB_CYCLES+3, and at no earlier edge.
REQ-009 The mode FSM SHALL step FREQ->AMP->PHASE->FREQ on each mode pulse; encoding 3 is unreachable and, if ever entered, SHALL return to FREQ on the next edge.
REQ-010 In FREQ mode:
  - up SHALL set state_freq to min(state_freq+FREQ_STEP, 4095);
  - down SHALL set state_freq to max(state_freq-FREQ_STEP, FREQ_MIN);
  - arithmetic SHALL be computed at 13 bits so it never wraps.
REQ-011 In AMP mode, up SHALL increment state_amp saturating at 7, and down SHALL decrement it saturating at 1; state_amp SHALL never be 0.
REQ-012 In PHASE mode, up and down SHALL add and subtract 1 modulo 256, so 255+1 gives 0 and 0-1 gives 255.
REQ-013 When up and down pulses occur in the same cycle, no parameter SHALL change.
REQ-014 When a mode pulse coincides with an up or down pulse, the up/down SHALL apply to the old mode and the mode SHALL advance on the same edge.
REQ-015 An en pulse SHALL toggle en and SHALL be independent of mode and of all other pulses.
REQ-016 Parameters not targeted by a pulse SHALL hold their value.

Reset
REQ-017 While rst is high at a clock edge, the block SHALL load:
  - en=1, state_freq=FREQ_INIT, state_amp=1, state_phase=0, mode=0;
  - all synchronizer flops, db levels and debounce counters = 0.
REQ-018 Reset asserted mid-debounce SHALL discard the partial count, and no pulse SHALL result from it.
REQ-019 A button held through reset release SHALL be treated as a new press, with its pulse timing per REQ-008 measured from the first edge after release.

Verification (DB_CYCLES=4)
REQ-020 The bench SHALL cover at least:
  - Reset, then hold btn_up from edge 1 -> state_freq 64->80 at edge 7; still 80 at edge 20 while held.
  - btn_up high for 3 cycles, then low -> state_freq remains 64.
  - Press btn_up 260 times in FREQ mode -> state_freq saturates at 4095; then 300 btn_down presses -> state_freq=1.
  - Press mode once, then btn_down once -> state_amp stays 1; press btn_up 8 times -> state_amp=7.
  - Press mode twice, then btn_down once -> state_phase=255; press btn_up once -> state_phase=0.
  - Align btn_up and btn_down so their db edges coincide -> no change; align btn_mode with btn_up in FREQ mode -> state_freq=80 and mode=1 on the same edge; press btn_en -> en=0; assert rst -> all values per REQ-017.

Source files
------------

// File: rtl/param_ctrl.sv
// param_ctrl: debounced four-button control of the sine generator's enable,
// frequency step, amplitude divisor and phase offset, with a mode FSM.
module param_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int FREQ_STEP = 16,
    parameter int FREQ_INIT = 64,
    parameter int FREQ_MIN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_en,
    output logic        en,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  mode
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [1:0] M_FREQ = 2'd0, M_AMP = 2'd1, M_PHASE = 2'd2;

    logic [3:0]  raw, s1, s2, db, db_q, pulse;
    logic [1:0]  state, state_nx;
    logic        up, dn;
    logic [12:0] f_up, f_dn;

    assign raw = {btn_en, btn_down, btn_up, btn_mode};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            db_q <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          d;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                d   <= 1'b0;
            end else if (s2[i] == d) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                d   <= s2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign db[i] = d;
    end

    // press = debounced rising edge; releases are ignored
    assign pulse = db & ~db_q;
    assign up    = pulse[1] & ~pulse[2];
    assign dn    = pulse[2] & ~pulse[1];

    always_ff @(posedge clk) begin
        state <= rst ? M_FREQ : state_nx;
    end

    always_comb begin
        state_nx = (state == 2'd3) ? M_FREQ :
                   !pulse[0]       ? state :
                   (state == M_PHASE) ? M_FREQ : state + 2'd1;
    end

    always_comb begin
        mode = state;
    end

    // 13-bit arithmetic so saturation is detected instead of wrapping
    assign f_up = {1'b0, state_freq} + 13'(FREQ_STEP);
    assign f_dn = {1'b0, state_freq} - 13'(FREQ_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= 1'b1;
            state_freq  <= 12'(FREQ_INIT);
            state_amp   <= 3'd1;
            state_phase <= 8'd0;
        end else begin
            if (pulse[3])
                en <= ~en;
            if (state == M_FREQ && up)
                state_freq <= f_up[12] ? 12'hfff : f_up[11:0];
            if (state == M_FREQ && dn)
                state_freq <= (f_dn[12] || f_dn[11:0] < 12'(FREQ_MIN)) ? 12'(FREQ_MIN) : f_dn[11:0];
            if (state == M_AMP && up && state_amp != 3'd7)
                state_amp <= state_amp + 3'd1;
            if (state == M_AMP && dn && state_amp > 3'd1)
                state_amp <= state_amp - 3'd1;
            if (state == M_PHASE && up)
                state_phase <= state_phase + 8'd1;
            if (state == M_PHASE && dn)
                state_phase <= state_phase - 8'd1;
        end
    end
endmodule
